fp_norm_pipe: RTL
=================

# fp_norm_pipe

Parametrised, pipelined post-add/sub normaliser for the floating-point ALU datapath. It takes a raw significand result and the pre-normalisation exponent, resolves sign, carry-out, zero, underflow and overflow, and returns a normalised significand and adjusted exponent. It sits between the significand adder/subtractor and the rounding/packing stage, with valid/ready flow control so the add path can be stalled by downstream logic.

## Interface
- `MANT_W`, 25: significand width including the carry/sign MSB. The hidden bit sits at `MANT_W-2`.
- `EXP_W`, 8: exponent width.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: input beat valid.
- `in_ready` out 1: block can accept a beat.
- `in_mode` in 1: 0 = unsigned magnitude with carry MSB; 1 = two's-complement significand.
- `in_sig` in `MANT_W`: raw significand.
- `in_exp` in `EXP_W`: exponent before normalisation.
- `out_valid` out 1: result valid.
- `out_ready` in 1: downstream accepts the result.
- `out_sig` out `MANT_W`: normalised significand. Bit `MANT_W-1` is always 0; bit `MANT_W-2` is 1 unless the result is zero or flushed.
- `out_exp` out `EXP_W`: adjusted exponent.
- `out_sign` out 1: 1 if the mode-1 input was negative.
- `out_sticky` out 1: OR of the bit shifted out by a right shift.
- `out_zero`, `out_uflow`, `out_oflow` out 1 each: status flags.

## Operation
- **Stage 1 (magnitude + count)**
  - In mode 1, if `in_sig[MANT_W-1]` is set, the magnitude is `-in_sig` and the sign is 1.
  - Otherwise the magnitude is `in_sig` and the sign is 0.
  - Mode 0 always gives sign 0.
  - `lzc` counts leading zeros of `mag[MANT_W-2:0]`; the count saturates at `MANT_W-1` when all bits are 0.
- **Stage 2 (shift + exponent), evaluated in this priority order:**
  1. mag == 0: zero=1, sig=0, exp=0. Sign is preserved; uflow and oflow stay 0.
  2. `mag[MANT_W-1]`=1 (carry; includes the most-negative mode-1 input): sig = mag>>1, sticky = mag[0], exp = in_exp+1.
     - If in_exp+1 == all-ones: oflow=1, exp=all-ones, sig=0 (infinity).
  3. Otherwise, if in_exp <= lzc: uflow=1, sig=0, exp=0 (flush to zero; no denormals).
  4. Otherwise: sig = mag<<lzc, exp = in_exp-lzc, sticky=0.
- Exponent arithmetic is done at `EXP_W+1` bits, unsigned, so wrap cannot occur. Saturation is as listed above.
- **Handshake:** each stage register loads when it is empty or its contents are leaving.
  - `in_ready = !s1_valid | s2_ready`, with `s2_ready = !out_valid | out_ready`.
  - A beat transfers on `valid & ready`.
  - Outputs hold stable while `out_valid & !out_ready`.

## Timing
- Latency is 2 cycles from the input handshake to `out_valid`. Throughput is 1 beat per cycle when `out_ready` stays high.
- `in_ready` depends combinationally on `out_ready` (no skid buffer).
- **Reset:** all valid bits clear; every output is 0 (`out_valid`=0, `out_sig`=0, `out_exp`=0, all flags 0). `in_ready` is 1 one cycle after reset deasserts.
- Reset mid-operation discards in-flight beats; no partial result is emitted.
- With both stages full and `out_ready` low, `in_ready` is 0. When `out_ready` rises, both stages advance in the same cycle and a new beat is accepted in that cycle.

## Structure
- Package `fp_norm_pkg`:
  - mode constants `NORM_UNSIGNED`=0 and `NORM_SIGNED`=1;
  - function `lzc_w(MANT_W)` = `$clog2(MANT_W)`;
  - status-flag bit indices.
- Sub-module `lzc_tree`: a parametrised leading-zero counter (width → count, all-zero flag) built as a log-depth tree. It replaces one-hot casex decoding and is reused by the int-to-float converter.
- Target implementation size is about 200 lines of RTL.

## Test plan
All vectors use `MANT_W`=25, `EXP_W`=8.
- **Aligned input:** mode 0, sig 0x0800000, exp 0x80 → sig 0x0800000, exp 0x80, all flags 0, out_valid 2 cycles later.
- **Maximum left shift:** mode 0, sig 0x0000001, exp 0x80 → sig 0x0800000, exp 0x69.
- **Carry, then overflow:**
  - mode 0, sig 0x1000001, exp 0x80 → sig 0x0800000, exp 0x81, sticky 1;
  - same sig with exp 0xFE → exp 0xFF, sig 0, oflow 1.
- **Signed inputs:**
  - mode 1, sig 0x1FFFFFF (-1), exp 0x80 → sign 1, sig 0x0800000, exp 0x69;
  - mode 1, sig 0x0000000 → zero 1, exp 0.
- **Underflow:** mode 0, sig 0x0000001, exp 0x10 → uflow 1, sig 0, exp 0.
- **Flow control and reset:**
  - Send 4 back-to-back beats with `out_ready` low for 3 cycles → `in_ready` drops after 2 beats, outputs hold stable, all 4 results arrive in order with none lost or duplicated.
  - Assert `rst_n` low with 2 beats in flight → `out_valid` is 0 immediately and no stale beat appears after release.

Source files
------------

// File: rtl/fp_norm_pkg.sv
// Shared definitions for the floating-point post-add/sub normaliser.
package fp_norm_pkg;

    // Interpretation of the raw significand coming from the adder
    localparam logic NORM_UNSIGNED = 1'b0;  // magnitude with carry MSB
    localparam logic NORM_SIGNED   = 1'b1;  // two's-complement significand

    // Bit positions inside the packed status-flag vector
    localparam int FLAG_ZERO   = 0;
    localparam int FLAG_UFLOW  = 1;
    localparam int FLAG_OFLOW  = 2;
    localparam int FLAG_STICKY = 3;
    localparam int FLAG_W      = 4;

    // Width of a leading-zero count over the MANT_W-1 bits below the carry bit
    function automatic int lzc_w(input int mant_w);
        return $clog2(mant_w);
    endfunction

endpackage

// File: rtl/lzc_tree.sv
// Parametrised leading-zero counter built as a log-depth binary tree.
// The vector is padded at the LSB end with ones up to a power of two, so an
// all-zero input naturally counts to WIDTH; the count saturates at WIDTH.
module lzc_tree #(
    parameter int WIDTH = 24,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] i_vec,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_zero
);

    localparam int LVLS  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int PAD_W = 1 << LVLS;

    logic [PAD_W-1:0] w_pad;
    logic [LVLS-1:0]  w_root_cnt;
    logic             w_root_zro;
    logic [CNT_W-1:0] w_cnt;

    if (PAD_W > WIDTH) begin : g_pad
        assign w_pad = {i_vec, {(PAD_W - WIDTH){1'b1}}};
    end else begin : g_nopad
        assign w_pad = i_vec;
    end

    // Node 0 of every level is the most significant group of bits.
    for (genvar lv = 0; lv < LVLS; lv++) begin : g_lvl
        for (genvar nd = 0; nd < (PAD_W >> (lv + 1)); nd++) begin : g_nd
            logic [lv:0] cnt;
            logic        zro;
            if (lv == 0) begin : g_leaf
                assign cnt = ~w_pad[PAD_W-1-2*nd];
                assign zro = ~w_pad[PAD_W-1-2*nd] & ~w_pad[PAD_W-2-2*nd];
            end else begin : g_merge
                assign zro = g_lvl[lv-1].g_nd[2*nd].zro & g_lvl[lv-1].g_nd[2*nd+1].zro;
                assign cnt = g_lvl[lv-1].g_nd[2*nd].zro ?
                             {1'b1, g_lvl[lv-1].g_nd[2*nd+1].cnt} :
                             {1'b0, g_lvl[lv-1].g_nd[2*nd].cnt};
            end
        end
    end

    assign w_root_cnt = g_lvl[LVLS-1].g_nd[0].cnt;
    assign w_root_zro = g_lvl[LVLS-1].g_nd[0].zro;

    // Saturate the count when the unpadded tree sees no set bit at all
    always_comb begin
        w_cnt = '0;
        if (w_root_zro) begin
            w_cnt = CNT_W'(WIDTH);
        end else begin
            w_cnt = CNT_W'(w_root_cnt);
        end
    end

    assign o_cnt  = w_cnt;
    assign o_zero = w_root_zro | (w_cnt == CNT_W'(WIDTH));

endmodule

// File: rtl/fp_norm_pipe.sv
// Two-stage post-add/sub normaliser: stage 1 resolves magnitude, sign and the
// leading-zero count; stage 2 shifts, adjusts the exponent and raises flags.
// Each stage register loads when empty or when its contents are leaving.
module fp_norm_pipe
    import fp_norm_pkg::*;
#(
    parameter int MANT_W = 25,
    parameter int EXP_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_mode,
    input  logic [MANT_W-1:0] in_sig,
    input  logic [EXP_W-1:0]  in_exp,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [MANT_W-1:0] out_sig,
    output logic [EXP_W-1:0]  out_exp,
    output logic              out_sign,
    output logic              out_sticky,
    output logic              out_zero,
    output logic              out_uflow,
    output logic              out_oflow
);

    localparam int LZC_W = lzc_w(MANT_W);

    // Stage 1 combinational
    logic [MANT_W-1:0] w_mag;
    logic              w_neg;
    logic [LZC_W-1:0]  w_lzc;
    logic              w_lzc_zero;

    // Stage 1 registers
    logic              r_s1_valid;
    logic [MANT_W-1:0] r_s1_mag;
    logic              r_s1_sign;
    logic              r_s1_zero;
    logic [EXP_W-1:0]  r_s1_exp;
    logic [LZC_W-1:0]  r_s1_lzc;

    // Stage 2 combinational
    logic [EXP_W:0]    w_exp_inc;
    logic [EXP_W:0]    w_exp_dec;
    logic              w_uflow;
    logic [MANT_W-1:0] w_nx_sig;
    logic [EXP_W-1:0]  w_nx_exp;
    logic [FLAG_W-1:0] w_nx_flags;

    // Output registers
    logic              r_out_valid;
    logic [MANT_W-1:0] r_out_sig;
    logic [EXP_W-1:0]  r_out_exp;
    logic              r_out_sign;
    logic [FLAG_W-1:0] r_out_flags;

    logic              w_s2_ready;
    logic              w_in_ready;

    assign w_s2_ready = ~r_out_valid | out_ready;
    assign w_in_ready = ~r_s1_valid | w_s2_ready;

    // Magnitude and sign of the raw significand
    always_comb begin
        w_mag = in_sig;
        w_neg = 1'b0;
        if ((in_mode == NORM_SIGNED) && in_sig[MANT_W-1]) begin
            w_mag = -in_sig;
            w_neg = 1'b1;
        end else begin
            w_mag = in_sig;
            w_neg = 1'b0;
        end
    end

    lzc_tree #(
        .WIDTH (MANT_W - 1),
        .CNT_W (LZC_W)
    ) u_lzc (
        .i_vec  (w_mag[MANT_W-2:0]),
        .o_cnt  (w_lzc),
        .o_zero (w_lzc_zero)
    );

    // Stage 1 register: capture magnitude, sign, count and exponent
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_mag   <= '0;
            r_s1_sign  <= 1'b0;
            r_s1_zero  <= 1'b0;
            r_s1_exp   <= '0;
            r_s1_lzc   <= '0;
        end else if (w_in_ready) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_mag  <= w_mag;
                r_s1_sign <= w_neg;
                r_s1_zero <= w_lzc_zero & ~w_mag[MANT_W-1];
                r_s1_exp  <= in_exp;
                r_s1_lzc  <= w_lzc;
            end
        end
    end

    // Exponent arithmetic one bit wider than the field so nothing wraps
    assign w_exp_inc = {1'b0, r_s1_exp} + {{EXP_W{1'b0}}, 1'b1};
    assign w_exp_dec = {1'b0, r_s1_exp} - {{(EXP_W + 1 - LZC_W){1'b0}}, r_s1_lzc};
    // exp - lzc borrowing or landing on zero means exp <= lzc
    assign w_uflow   = w_exp_dec[EXP_W] | (w_exp_dec[EXP_W-1:0] == {EXP_W{1'b0}});

    // Stage 2: zero, carry/overflow, underflow flush, then normal left shift
    always_comb begin
        w_nx_sig   = '0;
        w_nx_exp   = '0;
        w_nx_flags = '0;
        if (r_s1_zero) begin
            w_nx_flags[FLAG_ZERO] = 1'b1;
        end else if (r_s1_mag[MANT_W-1]) begin
            w_nx_flags[FLAG_STICKY] = r_s1_mag[0];
            // Anything at or past the all-ones exponent becomes infinity
            if (w_exp_inc >= {1'b0, {EXP_W{1'b1}}}) begin
                w_nx_flags[FLAG_OFLOW] = 1'b1;
                w_nx_exp               = {EXP_W{1'b1}};
                w_nx_sig               = '0;
            end else begin
                w_nx_sig = {1'b0, r_s1_mag[MANT_W-1:1]};
                w_nx_exp = w_exp_inc[EXP_W-1:0];
            end
        end else if (w_uflow) begin
            w_nx_flags[FLAG_UFLOW] = 1'b1;
        end else begin
            w_nx_sig = r_s1_mag << r_s1_lzc;
            w_nx_exp = w_exp_dec[EXP_W-1:0];
        end
    end

    // Output register: advance whenever downstream is free or consuming
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_sig   <= '0;
            r_out_exp   <= '0;
            r_out_sign  <= 1'b0;
            r_out_flags <= '0;
        end else if (w_s2_ready) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_sig   <= w_nx_sig;
                r_out_exp   <= w_nx_exp;
                r_out_sign  <= r_s1_sign;
                r_out_flags <= w_nx_flags;
            end
        end
    end

    assign in_ready   = w_in_ready;
    assign out_valid  = r_out_valid;
    assign out_sig    = r_out_sig;
    assign out_exp    = r_out_exp;
    assign out_sign   = r_out_sign;
    assign out_sticky = r_out_flags[FLAG_STICKY];
    assign out_zero   = r_out_flags[FLAG_ZERO];
    assign out_uflow  = r_out_flags[FLAG_UFLOW];
    assign out_oflow  = r_out_flags[FLAG_OFLOW];

endmodule
